// File: rtl/datapath_decode_if.sv
// ---------------------------------------------------------------------------
// datapath_decode_if
//
// Bundles the decode stage's pipeline-facing signals:
//   - IF/ID contents  : ifid_instr, ifid_pc2, ifid_valid
//   - execute control : ex_stall
//   - write-back port : wb_we, wb_addr, wb_data
//   - fetch control   : PCwrite, IFIDwrite, PCsrc, BT, flush
//   - ID/EX register  : idex_valid, idex_op, idex_imm_en, idex_rx, idex_ry,
//                       idex_rxdata, idex_rydata, idex_imm, idex_pc2
//
// The master modport is the decode stage; the slave modport is the
// surrounding pipeline (fetch, execute, write-back).
// ---------------------------------------------------------------------------
interface datapath_decode_if;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc2;
  logic        ifid_valid;
  logic        ex_stall;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  logic        PCwrite;
  logic        IFIDwrite;
  logic        PCsrc;
  logic [15:0] BT;
  logic        flush;

  logic        idex_valid;
  logic [3:0]  idex_op;
  logic        idex_imm_en;
  logic [2:0]  idex_rx;
  logic [2:0]  idex_ry;
  logic [15:0] idex_rxdata;
  logic [15:0] idex_rydata;
  logic [15:0] idex_imm;
  logic [15:0] idex_pc2;

  modport master (
    input  ifid_instr, ifid_pc2, ifid_valid, ex_stall, wb_we, wb_addr, wb_data,
    output PCwrite, IFIDwrite, PCsrc, BT, flush,
    output idex_valid, idex_op, idex_imm_en, idex_rx, idex_ry,
    output idex_rxdata, idex_rydata, idex_imm, idex_pc2
  );

  modport slave (
    output ifid_instr, ifid_pc2, ifid_valid, ex_stall, wb_we, wb_addr, wb_data,
    input  PCwrite, IFIDwrite, PCsrc, BT, flush,
    input  idex_valid, idex_op, idex_imm_en, idex_rx, idex_ry,
    input  idex_rxdata, idex_rydata, idex_imm, idex_pc2
  );
endinterface

// File: rtl/datapath_decode.sv
// ---------------------------------------------------------------------------
// datapath_decode
//
// Instruction-decode / register-read stage of the 16-bit pipelined core.
// Decodes the IF/ID instruction, reads the 8x16 register file (with
// same-cycle write-back bypass), detects load-use hazards, optionally
// resolves j/call early, drives the fetch controls and loads ID/EX.
//
// Ports:
//   clk     - clock, all state on posedge
//   reset   - asynchronous, active-low reset
//   dec_if  - datapath_decode_if.master (IF/ID in, write-back in,
//             ex_stall in, fetch controls out, ID/EX fields out)
//
// Build option:
//   DECODE_BRANCH_EN - when defined, j/call are resolved here (PCsrc=0,
//                      flush=1, BT = target). When undefined, PCsrc=1,
//                      flush=0, BT=0 and jumps are left to execute.
// ---------------------------------------------------------------------------
module datapath_decode #(
  parameter int RF_DEPTH = 8
) (
  input logic               clk,
  input logic               reset,
  datapath_decode_if.master dec_if
);

  typedef enum logic [3:0] {
    OP_MV   = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_CMP  = 4'd3,
    OP_LD   = 4'd4,
    OP_ST   = 4'd5,
    OP_MVHI = 4'd6,
    OP_J    = 4'd8,
    OP_JZ   = 4'd9,
    OP_JN   = 4'd10,
    OP_CALL = 4'd12
  } opcode_e;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic        imm_en;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] rxdata;
    logic [15:0] rydata;
    logic [15:0] imm;
    logic [15:0] pc2;
  } idex_t;

  // -------------------------------------------------------------------------
  // Instruction fields
  // -------------------------------------------------------------------------
  logic [15:0] instr;
  logic [3:0]  op;
  logic        imm_en;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [7:0]  imm8;
  logic [15:0] off11;

  assign instr  = dec_if.ifid_instr;
  assign op     = instr[3:0];
  assign imm_en = instr[4];
  assign rx     = instr[7:5];
  assign ry     = instr[10:8];
  assign imm8   = instr[15:8];
  // Jump offsets are halfword counts: sign-extend imm11 and scale by 2.
  assign off11  = {{4{instr[15]}}, instr[15:5], 1'b0};

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [15:0] rf_q [RF_DEPTH];

  // NOTE: the register file is built from resettable flops rather than a
  // RAM so that every register reads 0 straight out of reset; sequential
  // state is assigned with <= so all flops sample the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (dec_if.wb_we) begin
      rf_q[dec_if.wb_addr] <= dec_if.wb_data;
    end
  end

  // A write-back to the register being read wins over the stored value.
  logic [15:0] rx_data;
  logic [15:0] ry_data;

  assign rx_data = (dec_if.wb_we && dec_if.wb_addr == rx) ? dec_if.wb_data : rf_q[rx];
  assign ry_data = (dec_if.wb_we && dec_if.wb_addr == ry) ? dec_if.wb_data : rf_q[ry];

  // -------------------------------------------------------------------------
  // Decode: source usage and immediate
  // -------------------------------------------------------------------------
  logic        reads_rx;
  logic        reads_ry;
  logic        is_jump;
  logic [15:0] imm;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    reads_rx = 1'b0;
    reads_ry = 1'b0;
    is_jump  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_CMP, OP_ST: begin
        reads_rx = 1'b1;
        reads_ry = !imm_en;
      end
      OP_MV, OP_LD: begin
        reads_ry = !imm_en;
      end
      OP_MVHI: begin
        reads_rx = 1'b1;
      end
      OP_J, OP_JZ, OP_JN, OP_CALL: begin
        // Register form jumps through Rx; immediate form reads nothing.
        reads_rx = !imm_en;
        is_jump  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm = {{8{imm8[7]}}, imm8};
    if (op == OP_MVHI) begin
      imm = {imm8, 8'h00};
    end else if (is_jump) begin
      imm = off11;
    end
  end

  // -------------------------------------------------------------------------
  // Hazard and early branch
  // -------------------------------------------------------------------------
  idex_t idex_q;
  idex_t idex_d;
  idex_t decoded;
  logic  lu;
  logic  br;
  logic [15:0] bt;

  // The loaded register is ld's Rx; compare it with whatever this
  // instruction actually sources.
  assign lu = idex_q.valid && (idex_q.op == OP_LD) && dec_if.ifid_valid &&
              ((reads_rx && idex_q.rx == rx) || (reads_ry && idex_q.rx == ry));

`ifdef DECODE_BRANCH_EN
  assign br = dec_if.ifid_valid && (op == OP_J || op == OP_CALL);
  assign bt = imm_en ? (dec_if.ifid_pc2 + off11) : rx_data;
`else
  assign br = 1'b0;
  assign bt = 16'h0000;
`endif

  // -------------------------------------------------------------------------
  // Control and ID/EX next state
  // -------------------------------------------------------------------------
  always_comb begin
    decoded = '0;
    if (dec_if.ifid_valid) begin
      decoded.valid  = 1'b1;
      decoded.op     = op;
      decoded.imm_en = imm_en;
      decoded.rx     = rx;
      decoded.ry     = ry;
      decoded.rxdata = rx_data;
      decoded.rydata = ry_data;
      decoded.imm    = imm;
      decoded.pc2    = dec_if.ifid_pc2;
    end
  end

  logic pc_write;
  logic ifid_write;
  logic pc_src;
  logic flush;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    pc_src     = 1'b1;
    flush      = 1'b0;
    idex_d     = decoded;
    if (dec_if.ex_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_d     = idex_q;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_d     = '0;
    end else if (br) begin
      // The jump itself still goes down the pipe so call can link r7.
      pc_src = 1'b0;
      flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign dec_if.PCwrite     = pc_write;
  assign dec_if.IFIDwrite   = ifid_write;
  assign dec_if.PCsrc       = pc_src;
  assign dec_if.BT          = bt;
  assign dec_if.flush       = flush;

  assign dec_if.idex_valid  = idex_q.valid;
  assign dec_if.idex_op     = idex_q.op;
  assign dec_if.idex_imm_en = idex_q.imm_en;
  assign dec_if.idex_rx     = idex_q.rx;
  assign dec_if.idex_ry     = idex_q.ry;
  assign dec_if.idex_rxdata = idex_q.rxdata;
  assign dec_if.idex_rydata = idex_q.rydata;
  assign dec_if.idex_imm    = idex_q.imm;
  assign dec_if.idex_pc2    = idex_q.pc2;

endmodule

// File: tb/tb_datapath_decode.sv
// ---------------------------------------------------------------------------
// tb_datapath_decode
//
// Self-checking bench for datapath_decode. Expected ID/EX contents are
// pushed to a scoreboard queue when IF/ID is driven and popped after the
// clock edge that loads ID/EX. Fetch controls are checked combinationally
// between edges. Expectations follow DECODE_BRANCH_EN as compiled.
// ---------------------------------------------------------------------------
module tb_datapath_decode;

`ifdef DECODE_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic        imm_en;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] rxd;
    logic [15:0] ryd;
    logic [15:0] imm;
    logic [15:0] pc2;
  } idex_exp_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic [3:0]  op;
    logic        imm_en;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] rxd;
    logic [15:0] ryd;
    logic [15:0] imm;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  idex_exp_t sb_q[$];
  idex_exp_t last_exp;
  vec_t      vecs[10];

  datapath_decode_if bus ();

  datapath_decode dut (
    .clk    (clk),
    .reset  (reset),
    .dec_if (bus)
  );

  always #5 clk = ~clk;

  // ---------------- encoders ----------------
  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {5'b00000, ry, rx, 1'b0, op};
  endfunction

  function automatic logic [15:0] enc_i8(input logic [3:0] op, input logic [2:0] rx, input logic [7:0] i8);
    return {i8, rx, 1'b1, op};
  endfunction

  function automatic logic [15:0] enc_i11(input logic [3:0] op, input logic [10:0] i11);
    return {i11, 1'b1, op};
  endfunction

  function automatic idex_exp_t mk(input logic v, input logic [3:0] op, input logic ie,
                                   input logic [2:0] rx, input logic [2:0] ry,
                                   input logic [15:0] rxd, input logic [15:0] ryd,
                                   input logic [15:0] imm, input logic [15:0] pc2);
    idex_exp_t e;
    e.valid = v; e.op = op; e.imm_en = ie; e.rx = rx; e.ry = ry;
    e.rxd = rxd; e.ryd = ryd; e.imm = imm; e.pc2 = pc2;
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idex(input string tag);
    idex_exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, no expected ID/EX entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check($sformatf("%s.valid", tag),  16'(bus.idex_valid),  16'(e.valid));
    check($sformatf("%s.op", tag),     16'(bus.idex_op),     16'(e.op));
    check($sformatf("%s.imm_en", tag), 16'(bus.idex_imm_en), 16'(e.imm_en));
    check($sformatf("%s.rx", tag),     16'(bus.idex_rx),     16'(e.rx));
    check($sformatf("%s.ry", tag),     16'(bus.idex_ry),     16'(e.ry));
    check($sformatf("%s.rxdata", tag), bus.idex_rxdata,      e.rxd);
    check($sformatf("%s.rydata", tag), bus.idex_rydata,      e.ryd);
    check($sformatf("%s.imm", tag),    bus.idex_imm,         e.imm);
    check($sformatf("%s.pc2", tag),    bus.idex_pc2,         e.pc2);
  endtask

  task automatic check_ctrl(input string tag, input logic pcw, input logic ifw,
                            input logic pcs, input logic fl);
    check($sformatf("%s.PCwrite", tag),   16'(bus.PCwrite),   16'(pcw));
    check($sformatf("%s.IFIDwrite", tag), 16'(bus.IFIDwrite), 16'(ifw));
    check($sformatf("%s.PCsrc", tag),     16'(bus.PCsrc),     16'(pcs));
    check($sformatf("%s.flush", tag),     16'(bus.flush),     16'(fl));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic [15:0] pc2, input logic v);
    bus.ifid_instr = instr;
    bus.ifid_pc2   = pc2;
    bus.ifid_valid = v;
  endtask

  task automatic issue(input string tag, input idex_exp_t e);
    sb_q.push_back(e);
    step();
    check_idex(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idex_exp_t bubble;
    bubble = mk(1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Table: register file preloaded with rk = 16'hA000 | k*16'h0111.
    vecs[0] = '{enc_r(4'd1, 3'd1, 3'd2),     16'h0100, 4'd1,  1'b0, 3'd1, 3'd2, 16'hA111, 16'hA222, 16'h0002};
    vecs[1] = '{enc_i8(4'd2, 3'd3, 8'hF0),   16'h0102, 4'd2,  1'b1, 3'd3, 3'd0, 16'hA333, 16'hA000, 16'hFFF0};
    vecs[2] = '{enc_i8(4'd6, 3'd5, 8'h7C),   16'h0104, 4'd6,  1'b1, 3'd5, 3'd4, 16'hA555, 16'hA444, 16'h7C00};
    vecs[3] = '{enc_r(4'd3, 3'd6, 3'd7),     16'h0106, 4'd3,  1'b0, 3'd6, 3'd7, 16'hA666, 16'hA777, 16'h0007};
    vecs[4] = '{enc_i8(4'd4, 3'd4, 8'h81),   16'h0108, 4'd4,  1'b1, 3'd4, 3'd1, 16'hA444, 16'hA111, 16'hFF81};
    vecs[5] = '{enc_i11(4'd9, 11'h7FE),      16'h010A, 4'd9,  1'b1, 3'd6, 3'd7, 16'hA666, 16'hA777, 16'hFFFC};
    vecs[6] = '{enc_r(4'd10, 3'd2, 3'd0),    16'h010C, 4'd10, 1'b0, 3'd2, 3'd0, 16'hA222, 16'hA000, 16'h0004};
    vecs[7] = '{enc_r(4'd5, 3'd3, 3'd5),     16'h010E, 4'd5,  1'b0, 3'd3, 3'd5, 16'hA333, 16'hA555, 16'h0005};
    vecs[8] = '{enc_i8(4'd0, 3'd0, 8'h80),   16'h0110, 4'd0,  1'b1, 3'd0, 3'd0, 16'hA000, 16'hA000, 16'hFF80};
    vecs[9] = '{enc_r(4'd15, 3'd7, 3'd2),    16'h0112, 4'd15, 1'b0, 3'd7, 3'd2, 16'hA777, 16'hA222, 16'h0002};

    // ---------------- reset ----------------
    reset        = 1'b0;
    bus.ex_stall = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = 3'd0;
    bus.wb_data  = 16'h0;
    drive(16'h0, 16'h0, 1'b0);
    step();
    step();
    sb_q.push_back(bubble);
    check_idex("rst_low");
    check_ctrl("rst_low", 1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_low.BT", bus.BT, 16'h0000);
    reset = 1'b1;
    issue("rst_idle", bubble);
    check_ctrl("rst_idle", 1'b1, 1'b1, 1'b1, 1'b0);

    // Every register reads 0 after reset.
    for (int k = 0; k < 8; k++) begin
      drive(enc_r(4'd1, 3'(k), 3'(k)), 16'h0020, 1'b1);
      issue($sformatf("zero_r%0d", k),
            mk(1'b1, 4'd1, 1'b0, 3'(k), 3'(k), 16'h0, 16'h0, 16'(k), 16'h0020));
    end

    // Same-cycle write-back bypass into ID/EX.
    drive(enc_r(4'd1, 3'd1, 3'd3), 16'h0030, 1'b1);
    bus.wb_we = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'h1234;
    issue("bypass", mk(1'b1, 4'd1, 1'b0, 3'd1, 3'd3, 16'h0, 16'h1234, 16'h0003, 16'h0030));

    // Preload the register file.
    drive(16'h0, 16'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bus.wb_we = 1'b1; bus.wb_addr = 3'(k); bus.wb_data = 16'hA000 | (16'(k) * 16'h0111);
      step();
    end
    bus.wb_we = 1'b0;
    step();

    // ---------------- table-driven decode ----------------
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].instr, vecs[i].pc2, 1'b1);
      #1;
      check_ctrl($sformatf("vec%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
      issue($sformatf("vec%0d", i),
            mk(1'b1, vecs[i].op, vecs[i].imm_en, vecs[i].rx, vecs[i].ry,
               vecs[i].rxd, vecs[i].ryd, vecs[i].imm, vecs[i].pc2));
    end

    // ---------------- load-use via Rx ----------------
    drive(enc_i8(4'd4, 3'd2, 8'h00), 16'h0200, 1'b1);
    issue("lu_ld_r2", mk(1'b1, 4'd4, 1'b1, 3'd2, 3'd0, 16'hA222, 16'hA000, 16'h0000, 16'h0200));
    drive(enc_r(4'd1, 3'd2, 3'd4), 16'h0202, 1'b1);
    #1;
    check_ctrl("lu_rx_stall", 1'b0, 1'b0, 1'b1, 1'b0);
    issue("lu_rx_bubble", bubble);
    check_ctrl("lu_rx_release", 1'b1, 1'b1, 1'b1, 1'b0);
    issue("lu_rx_add", mk(1'b1, 4'd1, 1'b0, 3'd2, 3'd4, 16'hA222, 16'hA444, 16'h0004, 16'h0202));

    // ---------------- load-use via Ry ----------------
    drive(enc_i8(4'd4, 3'd4, 8'h00), 16'h0204, 1'b1);
    issue("lu_ld_r4", mk(1'b1, 4'd4, 1'b1, 3'd4, 3'd0, 16'hA444, 16'hA000, 16'h0000, 16'h0204));
    drive(enc_r(4'd1, 3'd1, 3'd4), 16'h0206, 1'b1);
    #1;
    check_ctrl("lu_ry_stall", 1'b0, 1'b0, 1'b1, 1'b0);
    issue("lu_ry_bubble", bubble);
    issue("lu_ry_add", mk(1'b1, 4'd1, 1'b0, 3'd1, 3'd4, 16'hA111, 16'hA444, 16'h0004, 16'h0206));

    // ---------------- ld followed by independent instruction ----------------
    drive(enc_i8(4'd4, 3'd3, 8'h00), 16'h0208, 1'b1);
    issue("nolu_ld_r3", mk(1'b1, 4'd4, 1'b1, 3'd3, 3'd0, 16'hA333, 16'hA000, 16'h0000, 16'h0208));
    drive(enc_r(4'd1, 3'd1, 3'd2), 16'h020A, 1'b1);
    #1;
    check_ctrl("nolu", 1'b1, 1'b1, 1'b1, 1'b0);
    issue("nolu_add", mk(1'b1, 4'd1, 1'b0, 3'd1, 3'd2, 16'hA111, 16'hA222, 16'h0002, 16'h020A));

    // ---------------- early branch: j immediate ----------------
    drive(enc_i11(4'd8, 11'd3), 16'h0010, 1'b1);
    #1;
    check_ctrl("j_imm", 1'b1, 1'b1, !BR_EN, BR_EN);
    check("j_imm.BT", bus.BT, BR_EN ? 16'h0016 : 16'h0000);
    issue("j_imm", mk(1'b1, 4'd8, 1'b1, 3'd3, 3'd0, 16'hA333, 16'hA000, 16'h0006, 16'h0010));

    // ---------------- call register form with bypassed target ----------------
    drive(enc_r(4'd12, 3'd5, 3'd0), 16'h0300, 1'b1);
    bus.wb_we = 1'b1; bus.wb_addr = 3'd5; bus.wb_data = 16'hBEEF;
    #1;
    check_ctrl("call_reg", 1'b1, 1'b1, !BR_EN, BR_EN);
    check("call_reg.BT", bus.BT, BR_EN ? 16'hBEEF : 16'h0000);
    issue("call_reg", mk(1'b1, 4'd12, 1'b0, 3'd5, 3'd0, 16'hBEEF, 16'hA000, 16'h000A, 16'h0300));
    bus.wb_we = 1'b0;

    // ---------------- call immediate imm11=5 ----------------
    drive(enc_i11(4'd12, 11'd5), 16'h0040, 1'b1);
    #1;
    check_ctrl("call_imm", 1'b1, 1'b1, !BR_EN, BR_EN);
    check("call_imm.BT", bus.BT, BR_EN ? 16'h004A : 16'h0000);
    last_exp = mk(1'b1, 4'd12, 1'b1, 3'd5, 3'd0, 16'hBEEF, 16'hA000, 16'h000A, 16'h0040);
    issue("call_imm", last_exp);

    // ---------------- ex_stall for three cycles ----------------
    drive(enc_r(4'd2, 3'd6, 3'd7), 16'h0400, 1'b1);
    bus.ex_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_ctrl($sformatf("stall%0d", c), 1'b0, 1'b0, 1'b1, 1'b0);
      issue($sformatf("stall%0d", c), last_exp);
    end
    bus.ex_stall = 1'b0;
    #1;
    check_ctrl("stall_rel", 1'b1, 1'b1, 1'b1, 1'b0);
    issue("stall_rel", mk(1'b1, 4'd2, 1'b0, 3'd6, 3'd7, 16'hA666, 16'hA777, 16'h0007, 16'h0400));

    // ---------------- stall overrides an early branch ----------------
    drive(enc_i11(4'd8, 11'd3), 16'h0010, 1'b1);
    bus.ex_stall = 1'b1;
    #1;
    check_ctrl("stall_j", 1'b0, 1'b0, 1'b1, 1'b0);

    // ---------------- reset asserted mid-stall ----------------
    #2;
    reset = 1'b0;
    #1;
    sb_q.push_back(bubble);
    check_idex("rst_mid");
    bus.ex_stall = 1'b0;
    drive(16'h0, 16'h0, 1'b0);
    #1;
    check_ctrl("rst_mid", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    drive(enc_r(4'd1, 3'd1, 3'd2), 16'h0500, 1'b1);
    issue("rst_rf", mk(1'b1, 4'd1, 1'b0, 3'd1, 3'd2, 16'h0000, 16'h0000, 16'h0002, 16'h0500));

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/datapath_decode.md
# datapath_decode

Instruction-decode / register-read stage of the 16-bit pipelined processor, directly downstream of the fetch stage. It consumes the IF/ID contents (instruction and PC+2), reads the 8×16 register file, detects load-use hazards, and resolves unconditional jumps early. It drives the fetch-stage control inputs `PCwrite`, `PCsrc` and `BT`, and loads the ID/EX pipeline register that feeds execute.

## Interface
- `RF_DEPTH`, 8: register count; register addresses are 3 bits.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `ifid_instr`  in  16  instruction held in IF/ID.
- `ifid_pc2`  in  16  PC+2 held in IF/ID.
- `ifid_valid`  in  1  IF/ID holds a real instruction (0 = bubble).
- `ex_stall`  in  1  execute cannot accept a new instruction this cycle.
- `wb_we`  in  1  write-back enable.
- `wb_addr`  in  3  write-back register.
- `wb_data`  in  16  write-back data.
- `PCwrite`  out  1  fetch may update PC.
- `IFIDwrite`  out  1  fetch may update IF/ID.
- `PCsrc`  out  1  1 = PC+2, 0 = `BT`.
- `BT`  out  16  branch target.
- `flush`  out  1  fetch must load a bubble into IF/ID next edge.
- `idex_valid`, `idex_op[3:0]`, `idex_imm_en`, `idex_rx[2:0]`, `idex_ry[2:0]`, `idex_rxdata[15:0]`, `idex_rydata[15:0]`, `idex_imm[15:0]`, `idex_pc2[15:0]`  out  ID/EX register fields.

## Operation
- Instruction format: op = [3:0], imm_en = [4], Rx = [7:5], Ry = [10:8], imm8 = [15:8], imm11 = [15:5].
- Opcodes: 0 mv, 1 add, 2 sub, 3 cmp, 4 ld, 5 st, 6 mvhi, 8 j, 9 jz, 10 jn, 12 call. All other opcodes pass through as no-ops.
- Immediate generation:
  - mvhi: `idex_imm` = {imm8, 8'h00}.
  - j/jz/jn/call: `idex_imm` = sext(imm11)<<1.
  - All others: `idex_imm` = sext(imm8).
- Register file: 8×16 flops, all cleared by reset. Written on posedge when `wb_we`=1.
- Read bypass: a read of `wb_addr` while `wb_we`=1 returns `wb_data` in the same cycle.
- Source use:
  - Rx is read by add, sub, cmp, st, mvhi, and by register-form j/jz/jn/call.
  - Ry is read only when imm_en=0 (the j/jz/jn/call register form reads Rx only).
- Load-use hazard (lu): asserted when all of the following hold:
  - `idex_valid`=1 and `idex_op`=ld,
  - `ifid_valid`=1,
  - `idex_rx` equals a register the current instruction reads.
- Early branch (br): asserted when `ifid_valid`=1 and op ∈ {j, call}.
  - imm_en=1: `BT` = `ifid_pc2` + sext(imm11)<<1.
  - imm_en=0: `BT` = bypassed Rx value.
  - jz and jn are resolved in execute, not here.
- Control outputs, in priority order:
  1. `ex_stall`=1: `PCwrite`=0, `IFIDwrite`=0. ID/EX holds all fields. `PCsrc`=1, `flush`=0.
  2. lu=1: `PCwrite`=0, `IFIDwrite`=0. ID/EX loads a bubble (`idex_valid`=0). `PCsrc`=1, `flush`=0.
  3. br=1: `PCwrite`=1, `PCsrc`=0, `flush`=1. ID/EX loads the jump with `idex_valid`=1, so call can link r7 in execute.
  4. Otherwise: `PCwrite`=1, `IFIDwrite`=1, `PCsrc`=1, `flush`=0. ID/EX loads the decoded instruction with `idex_valid`=`ifid_valid`.
- Bubbles: when `idex_valid`=0, all other ID/EX fields are don't-care; the implementation clears them to 0.

## Timing
- ID/EX latency is 1 cycle: an IF/ID value present before edge N appears on `idex_*` after edge N.
- `PCwrite`, `IFIDwrite`, `PCsrc`, `BT` and `flush` are combinational from the current IF/ID, ID/EX and `ex_stall`. They have no added latency.
- Load-use costs exactly one bubble. On the following cycle the ld has moved out of ID/EX, lu deasserts, and the instruction issues normally.
- A taken early branch costs one flushed slot.
- While reset is low:
  - all ID/EX fields are 0 and the register file is 0;
  - consequently `PCwrite`=1, `IFIDwrite`=1, `PCsrc`=1, `flush`=0.
- Reset asserted mid-stall clears ID/EX immediately. No stall state survives reset.
- A write-back in the same cycle as a read of the same register supplies the new value, for both the ID/EX data and `BT`.

## Configuration
- `DECODE_BRANCH_EN` defined: early branch resolution as described above.
- `DECODE_BRANCH_EN` undefined:
  - br is forced to 0, so `PCsrc`=1 and `flush`=0 permanently.
  - `BT` = 16'h0000.
  - j and call pass to ID/EX like any other instruction and are resolved in execute.

## Test plan
- Reset low, then high, with `ifid_valid`=0 → `idex_valid`=0; `PCwrite`=1, `PCsrc`=1, `flush`=0; every register reads 0.
- Write-back r3=16'h1234 in the same cycle as IF/ID holds add r1,r3 (imm_en=0) → after the edge, `idex_rydata`=16'h1234 and `idex_valid`=1.
- ld r2 in ID/EX, IF/ID holds add r2,r4 → one cycle with `PCwrite`=0, `IFIDwrite`=0 and an ID/EX bubble; the next cycle the add issues with `idex_rx`=2.
- IF/ID holds j with imm_en=1, imm11=3, `ifid_pc2`=16'h0010 → `BT`=16'h0016, `PCsrc`=0, `flush`=1; the jump appears in ID/EX with `idex_valid`=1.
- `ex_stall`=1 for 3 cycles with a valid instruction in IF/ID → `idex_*` unchanged and `PCwrite`=0 throughout; the instruction issues on the first cycle after `ex_stall` drops.
- With `DECODE_BRANCH_EN` undefined, IF/ID holds call with imm11=5 → `PCsrc`=1, `flush`=0, `BT`=16'h0000; `idex_op`=12 and `idex_imm`=16'h000A.
